gestor_botones: RTL

GESTOR_BOTONES -- requirements
Module: gestor_botones

---
 rtl/gestor_botones.sv | 90 +++++++++
 1 files changed

// File: rtl/gestor_botones.sv
// gestor_botones: debounced long-press detection for food/medicine/reset buttons plus decaying 0..3 levels (in: clk reset btn_*_n activo_*; out: senal_5seg_* reset_general nivel_*)
module gestor_botones #(
  parameter int DEB_CYC = 1_000_000,
  parameter int HOLD_CYC = 250_000_000,
  parameter int HOLD_RST_CYC = 150_000_000,
  parameter int DECAY_CYC = 500_000_000,
  parameter logic [1:0] LEVEL_INIT = 2'd3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_comida_n,
  input  logic btn_medicina_n,
  input  logic btn_reset_n,
  input  logic activo_comida,
  input  logic activo_medicina,
  output logic senal_5seg_comida,
  output logic senal_5seg_medicina,
  output logic reset_general,
  output logic [1:0] nivel_comida,
  output logic [1:0] nivel_medicina
);
  typedef enum logic [1:0] {IDLE, PRESSED, FIRED} st_t;
  logic [2:0] raw, pulse;
  assign raw = ~{btn_reset_n, btn_medicina_n, btn_comida_n};
  for (genvar g = 0; g < 3; g++) begin : ch
    localparam int LIM = (g == 2) ? HOLD_RST_CYC : HOLD_CYC;
    logic [1:0] sync;
    logic deb, p;
    logic [31:0] dcnt, hcnt;
    st_t st;
    always_ff @(posedge clk) begin
      if (reset) begin
        sync <= '0;
        deb <= 1'b0;
        dcnt <= '0;
        hcnt <= '0;
        st <= IDLE;
        p <= 1'b0;
      end else begin
        sync <= {sync[0], raw[g]};
        if (sync[1] == deb) dcnt <= '0;
        else if (dcnt == 32'(DEB_CYC - 1)) begin
          deb <= sync[1];
          dcnt <= '0;
        end else dcnt <= dcnt + 32'd1;
        p <= 1'b0;
        case (st)
          IDLE: if (deb) begin
            st <= PRESSED;
            hcnt <= '0;
          end
          PRESSED: if (!deb) st <= IDLE;
          else if (hcnt == 32'(LIM - 1)) begin
            p <= 1'b1;
            st <= FIRED;
          end else hcnt <= hcnt + 32'd1;
          FIRED: if (!deb) st <= IDLE;
          default: st <= IDLE;
        endcase
      end
    end
    assign pulse[g] = p;
  end
  assign senal_5seg_comida = pulse[0];
  assign senal_5seg_medicina = pulse[1];
  assign reset_general = pulse[2];
  logic [31:0] dec;
  logic ac_q, am_q, tick, inc_c, inc_m;
  assign tick = dec == 32'(DECAY_CYC - 1);
  assign inc_c = activo_comida & ~ac_q;
  assign inc_m = activo_medicina & ~am_q;
  function automatic logic [1:0] lvl_next(input logic [1:0] l, input logic i, input logic t);
    return (i && !t && l != 2'd3) ? l + 2'd1 : (t && !i && l != 2'd0) ? l - 2'd1 : l;
  endfunction
  always_ff @(posedge clk) begin
    if (reset) begin
      dec <= '0;
      ac_q <= 1'b0;
      am_q <= 1'b0;
      nivel_comida <= LEVEL_INIT;
      nivel_medicina <= LEVEL_INIT;
    end else begin
      dec <= tick ? '0 : dec + 32'd1;
      ac_q <= activo_comida;
      am_q <= activo_medicina;
      nivel_comida <= lvl_next(nivel_comida, inc_c, tick);
      nivel_medicina <= lvl_next(nivel_medicina, inc_m, tick);
    end
  end
endmodule
